atm_fsm_param: RTL and testbench

ATM_FSM_PARAM -- requirements
Module: atm_fsm_param

---
 rtl/atm_pkg.sv | 29 ++
 rtl/atm_timer.sv | 39 +++
 rtl/atm_fsm_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_atm_fsm_param.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM controller: state encodings, menu op codes
// and a small helper classifying states that wait on user input.
package atm_pkg;

    // Encodings are visible on state_o, so values are fixed explicitly.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPin    = 3'd1,
        StMenu   = 3'd2,
        StAmount = 3'd3,
        StExec   = 3'd4,
        StMore   = 3'd5,
        StEject  = 3'd6,
        StLock   = 3'd7
    } atm_state_e;

    typedef enum logic [1:0] {
        OpBalance  = 2'b00,
        OpWithdraw = 2'b01,
        OpDeposit  = 2'b10,
        OpExit     = 2'b11
    } atm_op_e;

    // States in which the inactivity timer runs and card removal aborts.
    function automatic logic is_wait_state(atm_state_e s);
        return s inside {StPin, StMenu, StAmount, StMore};
    endfunction

endpackage

// File: rtl/atm_timer.sv
// Inactivity timer: counts cycles while not cleared and flags when the
// count has reached LIMIT-1. Holds at the limit until cleared.
module atm_timer #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam logic [WIDTH-1:0] LastCnt = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign expired = (cnt_q == LastCnt);

    // Next count: clear wins, otherwise advance until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/atm_fsm_param.sv
// ATM session controller: card insert, PIN check with lockout, menu,
// withdraw/deposit/balance execution, inactivity timeout and card eject.
// Every output is driven straight from a register.
module atm_fsm_param
    import atm_pkg::*;
#(
    parameter int unsigned PIN_W       = 4,
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic [PIN_W-1:0] ref_pin,
    input  logic [AMT_W-1:0] bal_init,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_in,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic             amt_valid,
    input  logic [AMT_W-1:0] amt_in,
    input  logic             more_valid,
    input  logic             more_txn,
    output logic [2:0]       state_o,
    output logic [AMT_W-1:0] balance_o,
    output logic             dispense,
    output logic [AMT_W-1:0] dispense_amt,
    output logic             pin_err,
    output logic             txn_err,
    output logic             card_eject,
    output logic             card_locked
);

    localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TriesW-1:0] LastTry = TriesW'(MAX_TRIES - 1);

    atm_state_e        state_q, state_d;
    logic [AMT_W-1:0]  balance_q, balance_d;
    logic [PIN_W-1:0]  pin_ref_q, pin_ref_d;
    logic [TriesW-1:0] tries_q, tries_d;
    atm_op_e           op_q, op_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic              dispense_q, dispense_d;
    logic [AMT_W-1:0]  dispense_amt_q, dispense_amt_d;
    logic              pin_err_q, pin_err_d;
    logic              txn_err_q, txn_err_d;
    logic              card_eject_q, card_eject_d;
    logic              card_locked_q, card_locked_d;

    logic              strobe_accepted;
    logic              timer_clear;
    logic              timer_expired;
    logic [AMT_W:0]    dep_sum;

    // One extra bit catches deposit overflow.
    assign dep_sum = {1'b0, balance_q} + {1'b0, amt_q};

    // Idle time only accumulates while parked in a waiting state.
    assign timer_clear = !is_wait_state(state_q) || (state_d != state_q) || strobe_accepted;

    atm_timer #(
        .WIDTH (TimerW),
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    // Next-state and registered-output computation.
    // Priority in waiting states: card removal, then strobe, then timeout.
    always_comb begin
        state_d         = state_q;
        balance_d       = balance_q;
        pin_ref_d       = pin_ref_q;
        tries_d         = tries_q;
        op_d            = op_q;
        amt_d           = amt_q;
        dispense_d      = 1'b0;
        dispense_amt_d  = '0;
        pin_err_d       = 1'b0;
        txn_err_d       = 1'b0;
        strobe_accepted = 1'b0;

        case (state_q)
            StIdle: begin
                if (card_in) begin
                    state_d   = StPin;
                    balance_d = bal_init;
                    pin_ref_d = ref_pin;
                    tries_d   = '0;
                    op_d      = OpBalance;
                end
            end

            StPin: begin
                if (!card_in) begin
                    state_d = StIdle;
                end else if (pin_valid) begin
                    strobe_accepted = 1'b1;
                    if (pin_in == pin_ref_q) begin
                        state_d = StMenu;
                    end else begin
                        pin_err_d = 1'b1;
                        tries_d   = tries_q + 1'b1;
                        if (tries_q == LastTry) begin
                            state_d = StLock;
                        end
                    end
                end else if (timer_expired) begin
                    state_d = StEject;
                end
            end

            StMenu: begin
                if (!card_in) begin
                    state_d = StIdle;
                end else if (op_valid) begin
                    strobe_accepted = 1'b1;
                    op_d            = atm_op_e'(op);
                    case (atm_op_e'(op))
                        OpBalance:  state_d = StExec;
                        OpWithdraw: state_d = StAmount;
                        OpDeposit:  state_d = StAmount;
                        default:    state_d = StEject;
                    endcase
                end else if (timer_expired) begin
                    state_d = StEject;
                end
            end

            StAmount: begin
                if (!card_in) begin
                    state_d = StIdle;
                end else if (amt_valid) begin
                    strobe_accepted = 1'b1;
                    amt_d           = amt_in;
                    state_d         = StExec;
                end else if (timer_expired) begin
                    state_d = StEject;
                end
            end

            // Commits regardless of card_in; a removal is seen in MORE.
            StExec: begin
                state_d = StMore;
                case (op_q)
                    OpWithdraw: begin
                        if ((amt_q != '0) && (amt_q <= balance_q)) begin
                            balance_d      = balance_q - amt_q;
                            dispense_d     = 1'b1;
                            dispense_amt_d = amt_q;
                        end else begin
                            txn_err_d = 1'b1;
                        end
                    end
                    OpDeposit: begin
                        if (dep_sum[AMT_W]) begin
                            txn_err_d = 1'b1;
                        end else begin
                            balance_d = dep_sum[AMT_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end

            StMore: begin
                if (!card_in) begin
                    state_d = StIdle;
                end else if (more_valid) begin
                    strobe_accepted = 1'b1;
                    state_d         = more_txn ? StMenu : StEject;
                end else if (timer_expired) begin
                    state_d = StEject;
                end
            end

            StEject: begin
                if (!card_in) begin
                    state_d = StIdle;
                end
            end

            StLock: begin
                state_d = StLock;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Eject pulse lines up with the first cycle in EJECT.
        card_eject_d  = (state_d == StEject) && (state_q != StEject);
        card_locked_d = (state_d == StLock);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            balance_q      <= '0;
            pin_ref_q      <= '0;
            tries_q        <= '0;
            op_q           <= OpBalance;
            amt_q          <= '0;
            dispense_q     <= 1'b0;
            dispense_amt_q <= '0;
            pin_err_q      <= 1'b0;
            txn_err_q      <= 1'b0;
            card_eject_q   <= 1'b0;
            card_locked_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            balance_q      <= balance_d;
            pin_ref_q      <= pin_ref_d;
            tries_q        <= tries_d;
            op_q           <= op_d;
            amt_q          <= amt_d;
            dispense_q     <= dispense_d;
            dispense_amt_q <= dispense_amt_d;
            pin_err_q      <= pin_err_d;
            txn_err_q      <= txn_err_d;
            card_eject_q   <= card_eject_d;
            card_locked_q  <= card_locked_d;
        end
    end

    assign state_o      = state_q;
    assign balance_o    = balance_q;
    assign dispense     = dispense_q;
    assign dispense_amt = dispense_amt_q;
    assign pin_err      = pin_err_q;
    assign txn_err      = txn_err_q;
    assign card_eject   = card_eject_q;
    assign card_locked  = card_locked_q;

endmodule

// File: tb/tb_atm_fsm_param.sv
// Bench for atm_fsm_param: directed scenarios plus a randomized session run
// checked against a cycle-level behavioural model of the ATM rules.
module tb_atm_fsm_param;

    localparam int PIN_W       = 4;
    localparam int AMT_W       = 8;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 16;
    localparam int AMT_LIMIT   = 1 << AMT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             card_in = 1'b0;
    logic [PIN_W-1:0] ref_pin = '0;
    logic [AMT_W-1:0] bal_init = '0;
    logic             pin_valid = 1'b0;
    logic [PIN_W-1:0] pin_in = '0;
    logic             op_valid = 1'b0;
    logic [1:0]       op = '0;
    logic             amt_valid = 1'b0;
    logic [AMT_W-1:0] amt_in = '0;
    logic             more_valid = 1'b0;
    logic             more_txn = 1'b0;
    logic [2:0]       state_o;
    logic [AMT_W-1:0] balance_o;
    logic             dispense;
    logic [AMT_W-1:0] dispense_amt;
    logic             pin_err;
    logic             txn_err;
    logic             card_eject;
    logic             card_locked;

    int total = 0;
    int bad = 0;

    // Model of the session: mode numbers are the spec's state codes.
    int m_state = 0, m_bal = 0, m_pin = 0, m_tries = 0, m_op = 0, m_amt = 0, m_idle = 0;
    int m_damt = 0;
    bit m_disp = 0, m_pinerr = 0, m_txnerr = 0, m_eject = 0, m_locked = 0;

    always #5 clk = ~clk;

    atm_fsm_param #(
        .PIN_W       (PIN_W),
        .AMT_W       (AMT_W),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .card_in      (card_in),
        .ref_pin      (ref_pin),
        .bal_init     (bal_init),
        .pin_valid    (pin_valid),
        .pin_in       (pin_in),
        .op_valid     (op_valid),
        .op           (op),
        .amt_valid    (amt_valid),
        .amt_in       (amt_in),
        .more_valid   (more_valid),
        .more_txn     (more_txn),
        .state_o      (state_o),
        .balance_o    (balance_o),
        .dispense     (dispense),
        .dispense_amt (dispense_amt),
        .pin_err      (pin_err),
        .txn_err      (txn_err),
        .card_eject   (card_eject),
        .card_locked  (card_locked)
    );

    task automatic model_step();
        int  nxt;
        bit  acc;
        bit  waiting;
        m_disp   = 0;
        m_pinerr = 0;
        m_txnerr = 0;
        m_eject  = 0;
        if (!rst) begin
            m_state = 0; m_bal = 0; m_pin = 0; m_tries = 0; m_op = 0; m_amt = 0;
            m_idle = 0; m_damt = 0; m_locked = 0;
        end else begin
            nxt     = m_state;
            acc     = 0;
            waiting = (m_state == 1) || (m_state == 2) || (m_state == 3) || (m_state == 5);
            case (m_state)
                0: if (card_in) begin
                    nxt = 1; m_bal = int'(bal_init); m_pin = int'(ref_pin);
                    m_tries = 0; m_op = 0;
                end
                1: if (!card_in) nxt = 0;
                   else if (pin_valid) begin
                       acc = 1;
                       if (int'(pin_in) == m_pin) nxt = 2;
                       else begin
                           m_pinerr = 1;
                           m_tries++;
                           if (m_tries == MAX_TRIES) nxt = 7;
                       end
                   end else if (m_idle == TIMEOUT_CYC - 1) nxt = 6;
                2: if (!card_in) nxt = 0;
                   else if (op_valid) begin
                       acc  = 1;
                       m_op = int'(op);
                       nxt  = (m_op == 0) ? 4 : (m_op == 3) ? 6 : 3;
                   end else if (m_idle == TIMEOUT_CYC - 1) nxt = 6;
                3: if (!card_in) nxt = 0;
                   else if (amt_valid) begin
                       acc = 1; m_amt = int'(amt_in); nxt = 4;
                   end else if (m_idle == TIMEOUT_CYC - 1) nxt = 6;
                4: begin
                    nxt = 5;
                    if (m_op == 1) begin
                        if (m_amt > 0 && m_amt <= m_bal) begin
                            m_bal -= m_amt; m_disp = 1; m_damt = m_amt;
                        end else m_txnerr = 1;
                    end else if (m_op == 2) begin
                        if (m_bal + m_amt >= AMT_LIMIT) m_txnerr = 1;
                        else m_bal += m_amt;
                    end
                end
                5: if (!card_in) nxt = 0;
                   else if (more_valid) begin
                       acc = 1; nxt = more_txn ? 2 : 6;
                   end else if (m_idle == TIMEOUT_CYC - 1) nxt = 6;
                6: if (!card_in) nxt = 0;
                default: nxt = 7;
            endcase
            if (waiting && nxt == m_state && !acc) m_idle++;
            else m_idle = 0;
            m_eject  = (nxt == 6) && (m_state != 6);
            m_locked = (nxt == 7);
            m_state  = nxt;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pin(input int v);
        pin_valid = 1'b1; pin_in = PIN_W'(v); tick(); pin_valid = 1'b0;
    endtask

    task automatic do_op(input int v);
        op_valid = 1'b1; op = 2'(v); tick(); op_valid = 1'b0;
    endtask

    task automatic do_amt(input int v);
        amt_valid = 1'b1; amt_in = AMT_W'(v); tick(); amt_valid = 1'b0;
    endtask

    task automatic do_more(input bit v);
        more_valid = 1'b1; more_txn = v; tick(); more_valid = 1'b0;
    endtask

    task automatic insert(input int pin, input int bal);
        card_in = 1'b1; ref_pin = PIN_W'(pin); bal_init = AMT_W'(bal); tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if (balance_o !== '0) begin bad++; $display("FAIL reset_balance got=%0d exp=0", balance_o); end
        total++; if ({dispense, pin_err, txn_err, card_eject, card_locked} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {dispense, pin_err, txn_err, card_eject, card_locked});
        end
        total++; if (dispense_amt !== '0) begin bad++; $display("FAIL reset_damt got=%0d exp=0", dispense_amt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_withdraw();
        insert(5, 100);
        total++; if (state_o !== 3'd1 || balance_o !== 8'd100) begin
            bad++; $display("FAIL wd_insert got=%0d/%0d exp=1/100", state_o, balance_o);
        end
        do_pin(5);
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL wd_menu got=%0d exp=2", state_o); end
        do_op(1);
        do_amt(30);
        total++; if (state_o !== 3'd4 || dispense !== 1'b0) begin
            bad++; $display("FAIL wd_exec got=%0d/%0d exp=4/0", state_o, dispense);
        end
        tick();
        total++; if (dispense !== 1'b1 || dispense_amt !== 8'd30 || balance_o !== 8'd70 || state_o !== 3'd5) begin
            bad++; $display("FAIL wd_dispense got=%0d/%0d/%0d/%0d exp=1/30/70/5", dispense, dispense_amt, balance_o, state_o);
        end
        do_more(1'b0);
        total++; if (state_o !== 3'd6 || card_eject !== 1'b1 || dispense !== 1'b0) begin
            bad++; $display("FAIL wd_eject got=%0d/%0d/%0d exp=6/1/0", state_o, card_eject, dispense);
        end
        tick();
        total++; if (state_o !== 3'd6 || card_eject !== 1'b0) begin
            bad++; $display("FAIL wd_eject_pulse got=%0d/%0d exp=6/0", state_o, card_eject);
        end
        card_in = 1'b0;
        tick();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL wd_idle got=%0d exp=0", state_o); end
    endtask

    task automatic test_lockout();
        insert(9, 40);
        for (int i = 0; i < MAX_TRIES; i++) begin
            do_pin(i + 1);
            total++; if (pin_err !== 1'b1) begin bad++; $display("FAIL lock_pin_err%0d got=%0d exp=1", i, pin_err); end
            total++; if (state_o !== ((i == MAX_TRIES - 1) ? 3'd7 : 3'd1)) begin
                bad++; $display("FAIL lock_state%0d got=%0d", i, state_o);
            end
        end
        total++; if (card_locked !== 1'b1) begin bad++; $display("FAIL lock_level got=%0d exp=1", card_locked); end
        card_in = 1'b0;
        tick();
        tick();
        total++; if (state_o !== 3'd7 || card_locked !== 1'b1 || pin_err !== 1'b0) begin
            bad++; $display("FAIL lock_hold got=%0d/%0d/%0d exp=7/1/0", state_o, card_locked, pin_err);
        end
        rst = 1'b0;
        tick();
        total++; if (state_o !== 3'd0 || card_locked !== 1'b0) begin
            bad++; $display("FAIL lock_reset got=%0d/%0d exp=0/0", state_o, card_locked);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_txn_errors();
        insert(3, 20);
        do_pin(3);
        do_op(1); do_amt(21); tick();
        total++; if (txn_err !== 1'b1 || balance_o !== 8'd20 || dispense !== 1'b0) begin
            bad++; $display("FAIL over_wd got=%0d/%0d/%0d exp=1/20/0", txn_err, balance_o, dispense);
        end
        do_more(1'b1);
        total++; if (state_o !== 3'd2 || txn_err !== 1'b0) begin
            bad++; $display("FAIL more_menu got=%0d/%0d exp=2/0", state_o, txn_err);
        end
        do_op(1); do_amt(0); tick();
        total++; if (txn_err !== 1'b1 || balance_o !== 8'd20) begin
            bad++; $display("FAIL zero_wd got=%0d/%0d exp=1/20", txn_err, balance_o);
        end
        do_more(1'b0);
        card_in = 1'b0;
        tick();
        insert(3, 250);
        do_pin(3);
        do_op(2); do_amt(10); tick();
        total++; if (txn_err !== 1'b1 || balance_o !== 8'd250) begin
            bad++; $display("FAIL dep_ovf got=%0d/%0d exp=1/250", txn_err, balance_o);
        end
        do_more(1'b1);
        do_op(2); do_amt(5); tick();
        total++; if (txn_err !== 1'b0 || balance_o !== 8'd255) begin
            bad++; $display("FAIL dep_ok got=%0d/%0d exp=0/255", txn_err, balance_o);
        end
        do_more(1'b1);
        do_op(0); tick();
        total++; if (state_o !== 3'd5 || balance_o !== 8'd255 || {dispense, txn_err} !== 2'b00) begin
            bad++; $display("FAIL bal_query got=%0d/%0d/%b exp=5/255/00", state_o, balance_o, {dispense, txn_err});
        end
        do_more(1'b1);
        do_op(3);
        total++; if (state_o !== 3'd6 || card_eject !== 1'b1) begin
            bad++; $display("FAIL exit_eject got=%0d/%0d exp=6/1", state_o, card_eject);
        end
        card_in = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        insert(7, 10);
        do_pin(7);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL tmo_early got=%0d exp=2", state_o); end
        tick();
        total++; if (state_o !== 3'd6 || card_eject !== 1'b1) begin
            bad++; $display("FAIL tmo_eject got=%0d/%0d exp=6/1", state_o, card_eject);
        end
        card_in = 1'b0;
        tick();
    endtask

    task automatic test_removal_and_reset();
        insert(2, 77);
        do_pin(2);
        do_op(1);
        card_in = 1'b0;
        tick();
        total++; if (state_o !== 3'd0 || balance_o !== 8'd77) begin
            bad++; $display("FAIL rm_idle got=%0d/%0d exp=0/77", state_o, balance_o);
        end
        total++; if ({dispense, pin_err, txn_err, card_eject} !== 4'b0) begin
            bad++; $display("FAIL rm_pulses got=%b exp=0000", {dispense, pin_err, txn_err, card_eject});
        end
        insert(2, 50);
        do_pin(2);
        do_op(1);
        do_amt(10);
        rst = 1'b0;
        tick();
        total++; if (state_o !== 3'd0 || balance_o !== '0 || dispense !== 1'b0 || dispense_amt !== '0) begin
            bad++; $display("FAIL exec_reset got=%0d/%0d/%0d/%0d exp=0/0/0/0", state_o, balance_o, dispense, dispense_amt);
        end
        rst = 1'b1;
        card_in = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(299) != 0);
            if ($urandom_range(39) == 0) card_in = ~card_in;
            ref_pin    = PIN_W'($urandom);
            bal_init   = AMT_W'($urandom);
            pin_valid  = ($urandom_range(3) == 0);
            pin_in     = $urandom_range(1) ? PIN_W'(m_pin) : PIN_W'($urandom);
            op_valid   = ($urandom_range(3) == 0);
            op         = 2'($urandom);
            amt_valid  = ($urandom_range(2) == 0);
            amt_in     = ($urandom_range(7) == 0) ? '0 : AMT_W'($urandom);
            more_valid = ($urandom_range(3) == 0);
            more_txn   = ($urandom_range(2) != 0);
            tick();
            total++; if (state_o !== 3'(m_state)) begin
                bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", c, state_o, m_state);
            end
            total++; if (balance_o !== AMT_W'(m_bal)) begin
                bad++; $display("FAIL rnd_balance cyc=%0d got=%0d exp=%0d", c, balance_o, m_bal);
            end
            total++; if ({dispense, pin_err, txn_err, card_eject, card_locked} !==
                         {m_disp, m_pinerr, m_txnerr, m_eject, m_locked}) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c,
                    {dispense, pin_err, txn_err, card_eject, card_locked},
                    {m_disp, m_pinerr, m_txnerr, m_eject, m_locked});
            end
            if (m_disp) begin
                total++; if (dispense_amt !== AMT_W'(m_damt)) begin
                    bad++; $display("FAIL rnd_damt cyc=%0d got=%0d exp=%0d", c, dispense_amt, m_damt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_withdraw();
        test_lockout();
        test_txn_errors();
        test_timeout();
        test_removal_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
